// File: rtl/spi_master_param_if.sv
// Host/SPI-side signal bundle for spi_master_param.
// The master modport is the controller's view; slave is the host plus SPI device side.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_SS = 4,
    parameter int SEL_W  = 2
);
    logic              start;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [SEL_W-1:0]  ss_sel;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              done;
    logic              busy;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  start, cpol, cpha, lsb_first, clk_div, ss_sel, tx_data, miso,
        output rx_data, rx_valid, done, busy, sck, mosi, ss_n
    );

    modport slave (
        output start, cpol, cpha, lsb_first, clk_div, ss_sel, tx_data, miso,
        input  rx_data, rx_valid, done, busy, sck, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: all CPOL/CPHA modes, integer divider,
// selectable bit order and one-hot active-low chip selects.
//
// state   | meaning
// S_IDLE  | waiting for start, sck follows cpol, chip selects released
// S_SETUP | chip select asserted, one half-period before the first sck edge
// S_XFER  | 2*DATA_W sck edges, one every half-period
// S_HOLD  | one half-period after the last edge; done/rx_valid on its last cycle
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_SS = 4,
    parameter int SEL_W  = 2
) (
    input  logic clk,
    input  logic rst,
    spi_master_param_if.master bus
);
    localparam int EW = $clog2(DATA_W) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t            state_q;
    logic              cpha_q, lsb_q;
    logic [DIV_W-1:0]  clk_div_q, div_q;
    logic [EW-1:0]     edge_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
    logic              sck_q, mosi_q, busy_q, done_q, rx_valid_q;
    logic [NUM_SS-1:0] ss_n_q;

    logic              div_wrap, edge_evt, sample_evt, shift_evt, last_hold_d;
    logic              tx_head, start_head;
    logic [DATA_W-1:0] rx_next_d, tx_shift_d, start_shift_d;
    logic [NUM_SS-1:0] ss_dec;

    always_comb begin
        div_wrap      = (div_q == clk_div_q);
        edge_evt      = (state_q == S_XFER) && div_wrap;
        // Even edge index = leading edge; cpha picks which parity samples.
        sample_evt    = edge_evt && (edge_q[0] == cpha_q);
        shift_evt     = edge_evt && (cpha_q ? !edge_q[0] : (edge_q[0] && edge_q != LAST_EDGE));
        rx_next_d     = lsb_q ? {bus.miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], bus.miso};
        tx_head       = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
        tx_shift_d    = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        start_head    = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
        start_shift_d = bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
        // Registered done must already be high during the final HOLD cycle.
        last_hold_d   = (edge_evt && edge_q == LAST_EDGE && clk_div_q == '0) ||
                        (state_q == S_HOLD && !div_wrap && (div_q + DIV_W'(1)) == clk_div_q);
        for (int i = 0; i < NUM_SS; i++) ss_dec[i] = (int'(bus.ss_sel) != i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            clk_div_q  <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            if (last_hold_d) begin
                done_q     <= 1'b1;
                rx_valid_q <= 1'b1;
                rx_data_q  <= sample_evt ? rx_next_d : rx_sh_q;
            end
            case (state_q)
                S_IDLE: begin
                    sck_q  <= bus.cpol;
                    mosi_q <= 1'b0;
                    if (bus.start) begin
                        state_q   <= S_SETUP;
                        cpha_q    <= bus.cpha;
                        lsb_q     <= bus.lsb_first;
                        clk_div_q <= bus.clk_div;
                        tx_sh_q   <= bus.cpha ? bus.tx_data : start_shift_d;
                        mosi_q    <= bus.cpha ? 1'b0 : start_head;
                        rx_sh_q   <= '0;
                        div_q     <= '0;
                        edge_q    <= '0;
                        busy_q    <= 1'b1;
                        ss_n_q    <= ss_dec;
                    end
                end
                S_SETUP: begin
                    div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
                    if (div_wrap) state_q <= S_XFER;
                end
                S_XFER: begin
                    div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
                    if (edge_evt) begin
                        sck_q  <= ~sck_q;
                        edge_q <= edge_q + EW'(1);
                        if (edge_q == LAST_EDGE) state_q <= S_HOLD;
                    end
                    if (sample_evt) rx_sh_q <= rx_next_d;
                    if (shift_evt) begin
                        mosi_q  <= tx_head;
                        tx_sh_q <= tx_shift_d;
                    end
                end
                S_HOLD: begin
                    div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
                    if (div_wrap) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ss_n_q  <= '1;
                        mosi_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.sck      = sck_q;
    assign bus.mosi     = mosi_q;
    assign bus.ss_n     = ss_n_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: vector table of complete transfers,
// plus a hand-written mid-transfer reset sequence.
module tb_spi_master_param;
    logic clk = 1'b0;
    logic rst;
    logic loop_q;
    logic s_miso;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_param_if #(.DATA_W(8), .DIV_W(8), .NUM_SS(4), .SEL_W(3)) bus ();

    spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_SS(4), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    assign bus.miso = loop_q ? bus.mosi : s_miso;

    typedef struct {
        logic       cpol, cpha, lsb;
        logic [7:0] div;
        logic [2:0] sel;
        logic [7:0] tx, resp;
        logic       loop;
        int         restart;
        logic [7:0] exp_rx, exp_srx;
        int         exp_busy;
        logic [3:0] exp_ss;
        int         exp_mosi_hi;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bitof(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7-i];
    endfunction

    // Caller is positioned at a negedge; returns at the first idle negedge.
    task automatic run_vec(input vec_t v, input int idx);
        int busy_cyc = 0, edges = 0, mosi_hi = 0, done_cnt = 0, rv_cnt = 0;
        int done_at = -1, ss_bad = 0, s_idx;
        logic [7:0] got_rx = '0, s_rx = '0;
        logic sck_prev, lead, smp;
        bit finished = 0;
        loop_q        = v.loop;
        bus.cpol      = v.cpol;
        bus.cpha      = v.cpha;
        bus.lsb_first = v.lsb;
        bus.clk_div   = v.div;
        bus.ss_sel    = v.sel;
        bus.tx_data   = v.tx;
        bus.start     = 1'b1;
        sck_prev      = v.cpol;
        if (!v.cpha) begin s_miso = bitof(v.resp, 0, v.lsb); s_idx = 1; end
        else begin s_miso = 1'b0; s_idx = 0; end
        @(negedge clk);
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            bus.start = 1'b0;
            if (bus.busy) begin
                busy_cyc++;
                if (bus.ss_n !== v.exp_ss) ss_bad++;
                if (bus.mosi) mosi_hi++;
            end else finished = 1;
            if (bus.done) begin done_cnt++; done_at = busy_cyc; got_rx = bus.rx_data; end
            if (bus.rx_valid) rv_cnt++;
            if (bus.sck !== sck_prev) begin
                edges++;
                lead = (bus.sck != v.cpol);
                smp  = v.cpha ? !lead : lead;
                if (smp) s_rx = v.lsb ? {bus.mosi, s_rx[7:1]} : {s_rx[6:0], bus.mosi};
                else if (s_idx < 8) begin s_miso = bitof(v.resp, s_idx, v.lsb); s_idx++; end
            end
            sck_prev = bus.sck;
            if (!finished && v.restart != 0 && busy_cyc == v.restart) begin
                bus.start   = 1'b1;
                bus.tx_data = 8'hFF;
            end
            if (!finished) @(negedge clk);
        end
        chk($sformatf("v%0d completed", idx), 32'(finished), 32'd1);
        chk($sformatf("v%0d busy_cycles", idx), 32'(busy_cyc), 32'(v.exp_busy));
        chk($sformatf("v%0d ss_n_bad_cycles", idx), 32'(ss_bad), 32'd0);
        chk($sformatf("v%0d sck_edges", idx), 32'(edges), 32'd16);
        chk($sformatf("v%0d mosi_high_cycles", idx), 32'(mosi_hi), 32'(v.exp_mosi_hi));
        chk($sformatf("v%0d done_pulses", idx), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d rx_valid_pulses", idx), 32'(rv_cnt), 32'd1);
        chk($sformatf("v%0d done_cycle", idx), 32'(done_at), 32'(v.exp_busy));
        chk($sformatf("v%0d rx_data", idx), 32'(got_rx), 32'(v.exp_rx));
        if (!v.loop) chk($sformatf("v%0d slave_rx", idx), 32'(s_rx), 32'(v.exp_srx));
        chk($sformatf("v%0d idle_ss_n", idx), 32'(bus.ss_n), 32'hF);
        chk($sformatf("v%0d idle_sck", idx), 32'(bus.sck), 32'(v.cpol));
        chk($sformatf("v%0d idle_mosi", idx), 32'(bus.mosi), 32'd0);
    endtask

    initial begin
        int extra;
        //          cpol  cpha  lsb   div   sel   tx     resp   loop restart exp_rx exp_srx busy ss       mosi_hi
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0, 3'd1, 8'hA5, 8'h00, 1'b1, 0, 8'hA5, 8'h00, 18, 4'b1101, 10};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd3, 3'd0, 8'hC3, 8'h3C, 1'b0, 0, 8'h3C, 8'hC3, 72, 4'b1110, 32};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'd0, 3'd2, 8'h01, 8'h00, 1'b1, 0, 8'h01, 8'h00, 18, 4'b1011, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd0, 3'd5, 8'h5A, 8'h00, 1'b1, 0, 8'h5A, 8'h00, 18, 4'b1111, 8};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd1, 3'd3, 8'h3C, 8'h00, 1'b1, 5, 8'h3C, 8'h00, 36, 4'b0111, 16};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'd2, 3'd0, 8'h69, 8'h96, 1'b0, 0, 8'h96, 8'h69, 54, 4'b1110, 24};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'd0, 3'd2, 8'hB1, 8'h2D, 1'b0, 0, 8'h2D, 8'hB1, 18, 4'b1011, 10};

        rst = 1'b1; loop_q = 1'b1; s_miso = 1'b0;
        bus.start = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
        bus.clk_div = '0; bus.ss_sel = '0; bus.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("reset sck", 32'(bus.sck), 32'd0);
        chk("reset mosi", 32'(bus.mosi), 32'd0);
        chk("reset ss_n", 32'(bus.ss_n), 32'hF);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset rx_data", 32'(bus.rx_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Abort during bit 3 of a mode-0 loopback word.
        repeat (2) @(negedge clk);
        loop_q = 1'b1; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
        bus.clk_div = 8'd0; bus.ss_sel = 3'd1; bus.tx_data = 8'h96; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort pre busy", 32'(bus.busy), 32'd1);
        chk("abort pre ss_n", 32'(bus.ss_n), 32'hD);
        rst = 1'b1;
        #1;
        chk("abort ss_n", 32'(bus.ss_n), 32'hF);
        chk("abort sck", 32'(bus.sck), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort mosi", 32'(bus.mosi), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("abort rx_data", 32'(bus.rx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done || bus.rx_valid || bus.busy) extra++;
        end
        chk("abort no activity", 32'(extra), 32'd0);

        run_vec(vecs[0], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
